// File: rtl/cfu_simd_mac.sv
// Custom function unit: scalar/packed-SIMD add/sub plus multi-cycle signed dot-product accumulate.
// Build option: define CFU_SIMD_SAT_EN to make the lane add/sub saturate instead of wrap.
module cfu_simd_mac #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned LANES  = 4,
   parameter int unsigned CTRL_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              valid_i,
   input  logic [CTRL_W-1:0] cfu_ctrl_i,
   input  logic [XLEN-1:0]   src1_i,
   input  logic [XLEN-1:0]   src2_i,
   output logic              stall_o,
   output logic [XLEN-1:0]   rslt_o
);

   localparam int unsigned LW = XLEN / LANES;
   localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            state_q;
   logic [XLEN-1:0]   acc_q;
   logic [XLEN-1:0]   op1_q;
   logic [XLEN-1:0]   op2_q;
   logic [IW-1:0]     idx_q;

   logic [2:0]        funct3;
   logic              clr_acc;
   logic              dot_req;
   logic              unused_ctrl;
   logic [XLEN-1:0]   lane_rslt;
   logic signed [LW-1:0] dot_a;
   logic signed [LW-1:0] dot_b;
   logic [XLEN-1:0]   dot_prod;

   assign funct3      = cfu_ctrl_i[2:0];
   assign clr_acc     = cfu_ctrl_i[3];
   assign unused_ctrl = ^cfu_ctrl_i[CTRL_W-1:4];
   assign dot_req     = valid_i && (funct3 == 3'd5);

   // Per-lane add/sub with one extra bit so overflow is visible for saturation.
   always_comb begin
      logic signed [LW-1:0] la;
      logic signed [LW-1:0] lb;
      logic signed [LW:0]   ls;
      lane_rslt = '0;
      la        = '0;
      lb        = '0;
      ls        = '0;
      for (int k = 0; k < int'(LANES); k++) begin
         la = src1_i[k*LW +: LW];
         lb = src2_i[k*LW +: LW];
         ls = (funct3 == 3'd4) ? ((LW+1)'(la) - (LW+1)'(lb))
                               : ((LW+1)'(la) + (LW+1)'(lb));
`ifdef CFU_SIMD_SAT_EN
         if (ls[LW] != ls[LW-1])
            lane_rslt[k*LW +: LW] = ls[LW] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
         else
            lane_rslt[k*LW +: LW] = ls[LW-1:0];
`else
         lane_rslt[k*LW +: LW] = ls[LW-1:0];
`endif
      end
   end

   // Low XLEN bits of the sign-extended product equal the wrapped 2*LW-bit product.
   assign dot_a    = LW'(op1_q >> (LW * 32'(idx_q)));
   assign dot_b    = LW'(op2_q >> (LW * 32'(idx_q)));
   assign dot_prod = XLEN'(dot_a) * XLEN'(dot_b);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (dot_req) begin
                  op1_q   <= src1_i;
                  op2_q   <= src2_i;
                  idx_q   <= '0;
                  state_q <= S_BUSY;
               end else if (valid_i && !stall_i) begin
                  if (funct3 == 3'd6 && clr_acc) acc_q <= '0;
                  if (funct3 == 3'd7)            acc_q <= src1_i;
               end
            end
            S_BUSY: begin
               acc_q <= acc_q + dot_prod;
               idx_q <= idx_q + IW'(1);
               if (idx_q == LAST_IDX) state_q <= S_DONE;
            end
            S_DONE: begin
               if (!stall_i) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign stall_o = !rst_i && ((state_q == S_BUSY) || (state_q == S_IDLE && dot_req));

   // Result mux; single-cycle ops are combinational from the operands.
   always_comb begin
      rslt_o = '0;
      if (!rst_i && valid_i) begin
         if (state_q == S_DONE) begin
            rslt_o = acc_q;
         end else if (state_q == S_IDLE) begin
            case (funct3)
               3'd1:    rslt_o = src1_i + src2_i;
               3'd2:    rslt_o = src1_i - src2_i;
               3'd3:    rslt_o = lane_rslt;
               3'd4:    rslt_o = lane_rslt;
               3'd6:    rslt_o = acc_q;
               3'd7:    rslt_o = src1_i;
               default: rslt_o = '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cfu_simd_mac.sv
// Randomised bench for cfu_simd_mac against an arithmetic reference model of the accumulator and ops.
module tb_cfu_simd_mac;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned LANES  = 4;
   localparam int unsigned CTRL_W = 10;
   localparam int unsigned LW     = XLEN / LANES;

   logic              clk_i;
   logic              rst_i;
   logic              stall_i;
   logic              valid_i;
   logic [CTRL_W-1:0] cfu_ctrl_i;
   logic [XLEN-1:0]   src1_i;
   logic [XLEN-1:0]   src2_i;
   logic              stall_o;
   logic [XLEN-1:0]   rslt_o;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] acc_m  = 32'h0;

   cfu_simd_mac #(.XLEN(XLEN), .LANES(LANES), .CTRL_W(CTRL_W)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .stall_i    (stall_i),
      .valid_i    (valid_i),
      .cfu_ctrl_i (cfu_ctrl_i),
      .src1_i     (src1_i),
      .src2_i     (src2_i),
      .stall_o    (stall_o),
      .rslt_o     (rslt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Signed value of lane k.
   function automatic longint lane_val(input logic [31:0] v, input int k);
      longint m = longint'(1) << LW;
      longint x = longint'(v >> (k * LW)) % m;
      if (x >= (m / 2)) x = x - m;
      return x;
   endfunction

   function automatic logic [31:0] ref_lane(input bit sub, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r = 32'h0;
      longint      m = longint'(1) << LW;
      for (int k = 0; k < int'(LANES); k++) begin
         longint s = sub ? lane_val(a, k) - lane_val(b, k) : lane_val(a, k) + lane_val(b, k);
`ifdef CFU_SIMD_SAT_EN
         if (s > (m / 2) - 1) s = (m / 2) - 1;
         if (s < -(m / 2))    s = -(m / 2);
`endif
         s = ((s % m) + m) % m;
         r = r | (32'(s) << (k * LW));
      end
      return r;
   endfunction

   function automatic logic [31:0] ref_dot(input logic [31:0] a, input logic [31:0] b);
      longint s = 0;
      for (int k = 0; k < int'(LANES); k++) s += lane_val(a, k) * lane_val(b, k);
      return acc_m + 32'(s);
   endfunction

   function automatic logic [31:0] ref_single(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd1:    return a + b;
         3'd2:    return a - b;
         3'd3:    return ref_lane(1'b0, a, b);
         3'd4:    return ref_lane(1'b1, a, b);
         3'd6:    return acc_m;
         3'd7:    return a;
         default: return 32'h0;
      endcase
   endfunction

   // Single-cycle op: drive, check same-cycle result, retire on the edge unless stalled.
   task automatic run_single(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [31:0] a, input logic [31:0] b, input logic si);
      logic [31:0] exp = ref_single(f3, a, b);
      valid_i = 1'b1; cfu_ctrl_i = {f7, f3}; src1_i = a; src2_i = b; stall_i = si;
      #1;
      check({tag, "_rslt"}, rslt_o, exp);
      check({tag, "_stall"}, 32'(stall_o), 32'h0);
      @(posedge clk_i); #1;
      if (!si) begin
         if (f3 == 3'd7) acc_m = a;
         if (f3 == 3'd6 && f7[0]) acc_m = 32'h0;
      end
   endtask

   task automatic run_dot(input string tag, input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [31:0] exp = ref_dot(a, b);
      int cnt = 0;
      valid_i = 1'b1; cfu_ctrl_i = {7'($urandom), 3'd5}; src1_i = a; src2_i = b; stall_i = 1'b0;
      #1;
      while (stall_o === 1'b1 && cnt < 20) begin
         cnt++;
         @(posedge clk_i); #1;
      end
      check({tag, "_stall_cycles"}, 32'(cnt), 32'(LANES + 1));
      check({tag, "_rslt"}, rslt_o, exp);
      stall_i = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk_i); #1;
         check({tag, "_hold_rslt"}, rslt_o, exp);
         check({tag, "_hold_stall"}, 32'(stall_o), 32'h0);
      end
      stall_i = 1'b0;
      @(posedge clk_i); #1;
      acc_m = exp;
   endtask

   task automatic run_idle(input string tag);
      valid_i = 1'b0; cfu_ctrl_i = 10'($urandom); src1_i = $urandom; src2_i = $urandom; stall_i = 1'($urandom);
      #1;
      check({tag, "_rslt"}, rslt_o, 32'h0);
      check({tag, "_stall"}, 32'(stall_o), 32'h0);
      @(posedge clk_i); #1;
   endtask

   initial begin
      rst_i = 1'b1; stall_i = 1'b0; valid_i = 1'b1; cfu_ctrl_i = 10'd5;
      src1_i = 32'h01020304; src2_i = 32'h05060708;
      @(posedge clk_i); #1;
      check("reset_stall", 32'(stall_o), 32'h0);
      check("reset_rslt", rslt_o, 32'h0);
      @(posedge clk_i); #1;
      rst_i = 1'b0; valid_i = 1'b0;
      run_idle("idle");
      run_single("rdacc_reset", 3'd6, 7'd0, 32'h0, 32'h0, 1'b0);

      // Directed cases
      run_single("add_wrap", 3'd1, 7'd0, 32'hFFFFFFFF, 32'h1, 1'b0);
      check("add_wrap_const", ref_single(3'd1, 32'hFFFFFFFF, 32'h1), 32'h0);
      run_single("lane_add", 3'd3, 7'd0, 32'h7F01FF80, 32'h01010180, 1'b0);
`ifdef CFU_SIMD_SAT_EN
      check("lane_add_const", ref_lane(1'b0, 32'h7F01FF80, 32'h01010180), 32'h7F020080);
`else
      check("lane_add_const", ref_lane(1'b0, 32'h7F01FF80, 32'h01010180), 32'h80020000);
`endif
      run_single("lane_sub", 3'd4, 7'd0, 32'h80017F00, 32'h01FF8001, 1'b0);
      run_single("wracc", 3'd7, 7'd0, 32'd10, 32'h0, 1'b0);
      run_dot("dot1", 32'h01020304, 32'h05060708, 0);
      check("dot1_acc_const", acc_m, 32'h50);
      run_single("rdacc_clr", 3'd6, 7'd1, 32'h0, 32'h0, 1'b0);
      run_single("rdacc_after_clr", 3'd6, 7'd0, 32'h0, 32'h0, 1'b0);
      run_single("wracc2", 3'd7, 7'd0, 32'h50, 32'h0, 1'b0);
      run_dot("dot_neg", 32'hFF000000, 32'h7F000000, 0);
      check("dot_neg_acc_const", acc_m, 32'hFFFFFFD1);
      run_single("wracc0", 3'd7, 7'd0, 32'h0, 32'h0, 1'b0);
      run_dot("dot_hold", 32'h01020304, 32'h05060708, 3);
      run_single("rdacc_hold", 3'd6, 7'd0, 32'h0, 32'h0, 1'b0);
      run_dot("dot_b2b_a", 32'h7F7F7F7F, 32'h80808080, 0);
      run_dot("dot_b2b_b", 32'h80808080, 32'h80808080, 1);
      run_single("rdacc_b2b", 3'd6, 7'd0, 32'h0, 32'h0, 1'b0);

      // Randomised mix
      for (int i = 0; i < 80; i++) begin
         logic [2:0] f3 = 3'($urandom);
         int sel = $urandom_range(0, 9);
         if (sel == 0)       run_idle("rnd_idle");
         else if (f3 == 3'd5) run_dot("rnd_dot", $urandom, $urandom, $urandom_range(0, 3));
         else if (f3 == 3'd6 && sel < 8)
            run_single("rnd_rdacc", 3'd6, 7'($urandom), 32'($urandom), 32'($urandom), 1'b0);
         else
            run_single("rnd_op", f3, 7'($urandom), 32'($urandom), 32'($urandom), 1'($urandom_range(0, 3) == 0));
      end

      // Reset pulse in the middle of a DOT
      run_single("wracc_pre_rst", 3'd7, 7'd0, 32'h12345678, 32'h0, 1'b0);
      valid_i = 1'b1; cfu_ctrl_i = 10'd5; src1_i = 32'h01020304; src2_i = 32'h05060708; stall_i = 1'b0;
      #1;
      check("rst_dot_T_stall", 32'(stall_o), 32'h1);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      #1;
      check("rst_forced_stall", 32'(stall_o), 32'h0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      acc_m = 32'h0;
      run_single("rst_rdacc", 3'd6, 7'd0, 32'h0, 32'h0, 1'b0);
      run_dot("post_rst_dot", 32'hFEFDFCFB, 32'h01020304, 0);
      run_single("post_rst_rdacc", 3'd6, 7'd1, 32'h0, 32'h0, 1'b0);
      run_idle("final_idle");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cfu_simd_mac.md
# cfu_simd_mac

Parametrised custom function unit for the CFU Proving Ground core. It sits in the core's execute stage on the same custom-instruction interface as the baseline CFU. It keeps the scalar add/sub operations and adds packed-SIMD lane add/sub plus a multi-cycle signed dot-product accumulate into an internal accumulator. Multi-cycle operations hold the pipeline through `stall_o`.

## Interface
- `XLEN`, 32: datapath width; must equal core `XLEN`.
- `LANES`, 4: packed lanes per operand, one of {1, 2, 4}. Lane width `LW = XLEN/LANES`. Lane k is bits `[k*LW +: LW]`.
- `CTRL_W`, 10: width of `cfu_ctrl_i`.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `stall_i` in 1: core pipeline stall; the instruction retires only in a cycle with `stall_i`=0 and `stall_o`=0.
- `valid_i` in 1: a CFU instruction is present in execute.
- `cfu_ctrl_i` in CTRL_W: `[2:0]` = funct3, `[9:3]` = funct7.
- `src1_i` in XLEN: rs1 operand.
- `src2_i` in XLEN: rs2 operand.
- `stall_o` out 1: CFU busy; the core must hold `valid_i`, `cfu_ctrl_i` and operands stable while it is 1.
- `rslt_o` out XLEN: result; 0 whenever `valid_i`=0.

## Operation
- funct3 0: result 0.
- funct3 1: result `src1+src2`, modulo 2^XLEN.
- funct3 2: result `src1−src2`, modulo 2^XLEN.
- funct3 3: per-lane `src1[k]+src2[k]`; lanes independent, no carry between lanes.
- funct3 4: per-lane `src1[k]−src2[k]`.
- funct3 5 (DOT): `acc += Σ_k signed(src1[k])·signed(src2[k])`.
  - Each product is 2·LW bits, sign-extended to XLEN; the sum wraps modulo 2^XLEN.
  - Result is the updated acc.
- funct3 6 (RDACC): result is `acc`. If funct7[0]=1, acc is cleared to 0 at retire.
- funct3 7 (WRACC): `acc ← src1` at retire; result is `src1`.
- funct7 bits not listed are ignored.
- Accumulator:
  - acc is XLEN bits, reset to 0.
  - Single-cycle ops (RDACC, WRACC) write acc only in the retire cycle, so there is exactly one update per instruction.
- DOT state machine:
  - IDLE: `stall_o = valid_i & (funct3==5)`, combinational. On that condition, latch `src1`/`src2` into operand registers, set lane index to 0, go to BUSY.
  - BUSY: each cycle add lane[idx] product to acc and increment idx. When idx==LANES−1, go to DONE. `stall_i` has no effect in BUSY. `stall_o`=1.
  - DONE: `stall_o`=0 and `rslt_o`=acc. If `stall_i`=0, go to IDLE (retire); otherwise hold DONE with `rslt_o` stable.
- Reset mid-operation: the next state is IDLE, acc=0, and the partial DOT is discarded.
- While `rst_i`=1, `stall_o` is forced to 0.
- Reset values: `stall_o`=0, `rslt_o`=0, state IDLE, acc=0, operand registers 0.

## Timing
- funct3 0–4, 6, 7:
  - Latency 0: `rslt_o` is combinational from the inputs in the same cycle.
  - `stall_o`=0.
- DOT, with valid first seen in cycle T:
  - `stall_o`=1 in cycles T .. T+LANES.
  - Result is valid in cycle T+LANES+1.
  - Minimum occupancy is LANES+2 cycles.
- Back-to-back DOTs: the second DOT is seen in IDLE on the cycle after retire; no bubble is inserted by the CFU.
- acc changes only on a clock edge. RDACC in the cycle after a DOT retires sees the DOT result.

## Configuration
- Macro `CFU_SIMD_SAT_EN`.
- Defined: funct3 3/4 saturate each lane to the signed LW range [−2^(LW−1), 2^(LW−1)−1].
- Undefined: lanes wrap modulo 2^LW.
- The scalar ops and DOT wrap in both builds.

## Test plan
- XLEN=32, LANES=4, funct3=1, src1=0xFFFFFFFF, src2=1 → `rslt_o`=0x00000000 and `stall_o`=0 in the same cycle.
- funct3=3, src1=0x7F01FF80, src2=0x01010180:
  - Without the macro → 0x80020000.
  - With `CFU_SIMD_SAT_EN` → 0x7F020080.
- WRACC src1=10, then DOT src1=0x01020304, src2=0x05060708:
  - `stall_o` high 5 cycles, then `rslt_o`=0x50.
  - Follow with DOT src1=0xFF000000, src2=0x7F000000 → acc=0x50−127=0xFFFFFFD1.
- RDACC with funct7[0]=1 returns 0x50; an immediately following RDACC returns 0.
- `stall_i` held high 3 cycles in DONE → `rslt_o` is stable for all 3 cycles, and acc is updated exactly once (RDACC afterwards shows a single accumulate).
- `rst_i` pulsed in cycle T+2 of a DOT:
  - Cycle T+3: `stall_o`=0, state IDLE, RDACC returns 0.
  - A new DOT afterwards completes normally.
